dmem_stack_ctrl: RTL and testbench
==================================

Name: dmem_stack_ctrl

Overview:
- Sequencer for the 256x8 data memory: owns the stack pointer and drives the memory control lines `wr`, `s2` (address select) and `s5` (write-data select).
- Executes LD, ST, PUSH, POP, CALL and RET as short multi-cycle operations, with the stack growing downward.
- Sits between the instruction decode/control unit and the data memory. Decode issues one operation per valid/ready handshake; the block signals completion and any stack fault.

Parameters:
- SP_INIT, 8'hFF, stack pointer value after reset and the stack-empty marker.
- SP_LIMIT, 8'h80, lowest legal stack address. A PUSH or CALL is refused when sp == SP_LIMIT.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst_n  input  1  synchronous active-low reset.
- op_valid  input  1  decode presents an operation.
- op_code  input  3  000 LD, 001 ST, 010 PUSH, 011 POP, 100 CALL, 101 RET, 110 SPSET, 111 reserved.
- sp_wdata  input  8  new stack pointer value for SPSET.
- op_ready  output  1  high only in IDLE.
- op_done  output  1  one-cycle pulse when the operation completes.
- op_err  output  1  one-cycle pulse with op_done when the operation is refused.
- sp  output  8  current stack pointer; drives the memory SP address input.
- wr  output  1  memory write enable.
- s2  output  1  address select: 1 = sp, 0 = R0.
- s5  output  1  write-data select: 1 = Rn, 0 = NPC.
- rd_load  output  1  load memory dataOut into Rn this cycle (LD, POP).
- pc_load  output  1  load memory dataOut into PC this cycle (RET).

Behaviour:
- Reset (rst_n low at posedge):
  - state goes to IDLE and sp to SP_INIT.
  - op_ready reads 1 after reset; every other output reads 0.
  - Reset has priority over any operation in flight. No write is issued in the reset cycle, and an aborted operation produces no op_done.
- Handshake:
  - An operation is accepted at a posedge with op_valid && op_ready; op_code and sp_wdata are latched at that edge.
  - op_valid while busy is ignored. Decode must hold op_valid until op_ready.
  - A new operation may be accepted in the cycle after op_done.
- FSM states: IDLE, DEC, ACC, INC. The op_done cycle is the final state; the next edge returns to IDLE.
  - LD: ACC (s2=0, rd_load=1, op_done). Latency 1 cycle after accept.
  - ST: ACC (s2=0, s5=1, wr=1, op_done).
  - PUSH: DEC (sp <= sp-1), then ACC (s2=1, s5=1, wr=1, op_done). Pre-decrement, so the new sp addresses the written byte.
  - CALL: same as PUSH with s5=0 (NPC is written).
  - POP: ACC (s2=1, rd_load=1), then INC (sp <= sp+1, op_done). Post-increment.
  - RET: same as POP with pc_load=1 in place of rd_load.
  - In every state not listed, wr, rd_load and pc_load are 0. In those states s2 and s5 hold the value they had in the last cycle for the same operation; in IDLE both are 0.
- Fault handling, decided in the first cycle after accept:
  - PUSH or CALL with sp == SP_LIMIT (overflow): no DEC, no write.
  - POP or RET with sp == SP_INIT (underflow): no read, no pc_load or rd_load.
  - Reserved op_code 111.
  - In each case: one cycle with op_done=1 and op_err=1, sp unchanged, then IDLE.
- Arithmetic: sp is 8-bit. Wrap-around is impossible given the fault checks, provided SP_LIMIT < SP_INIT. SPSET bypasses the checks (see Optional Feature).
- wr must never be high in the same cycle as rd_load or pc_load.

Optional Feature:
- Macro: DMEM_STACK_CTRL_SPSET_EN.
- Defined: op_code 110 (SPSET) takes one cycle, ACC. sp <= latched sp_wdata at its end; op_done=1, op_err=0; no memory access.
- Undefined: 110 is treated as reserved and gives op_err with op_done; sp_wdata is ignored. The port is present in both builds.

Test Plan:
- Reset, then PUSH with Rn=8'h5A -> DEC cycle; ACC has wr=1, s2=1, s5=1, sp=8'hFE; mem[FE]=5A; op_done in ACC.
- CALL with NPC=8'h21, then RET -> mem[FD]=21; RET ACC has pc_load=1 while dataOut=21; sp returns to FE after INC with op_done.
- POP immediately after reset -> op_done=1 and op_err=1 one cycle after accept; rd_load never high; sp stays FF.
- Push until sp=8'h80, then PUSH -> op_err=1, wr stays 0, sp stays 80.
- ST with R0=8'h10, Rn=8'h33, then LD R0=8'h10 -> wr=1 with s2=0; LD cycle has rd_load=1 and dataOut=33; sp unchanged.
- Pull rst_n low during the DEC cycle of a PUSH -> no wr, no op_done; sp=FF and op_ready=1 after reset. Then SPSET with sp_wdata=8'hC0 -> with the macro, sp=C0 and no error; without it, op_err=1.

Source files
------------

// File: rtl/dmem_stack_ctrl_if.sv
// dmem_stack_ctrl_if: operation handshake and data-memory control bundle
// between the decode/control unit (master) and the stack controller (slave).
interface dmem_stack_ctrl_if;
  logic       op_valid;
  logic [2:0] op_code;
  logic [7:0] sp_wdata;
  logic       op_ready;
  logic       op_done;
  logic       op_err;
  logic [7:0] sp;
  logic       wr;
  logic       s2;
  logic       s5;
  logic       rd_load;
  logic       pc_load;

  // Decode side: issues operations, observes completion and memory controls.
  modport master (
    output op_valid, op_code, sp_wdata,
    input  op_ready, op_done, op_err, sp, wr, s2, s5, rd_load, pc_load
  );

  // Controller side: accepts operations, drives the memory control lines.
  modport slave (
    input  op_valid, op_code, sp_wdata,
    output op_ready, op_done, op_err, sp, wr, s2, s5, rd_load, pc_load
  );
endinterface

// File: rtl/dmem_stack_ctrl.sv
// dmem_stack_ctrl: sequencer for the 256x8 data memory. Owns the downward
// growing stack pointer and runs LD/ST/PUSH/POP/CALL/RET as short multi-cycle
// operations, raising op_err for stack overflow/underflow and reserved codes.
// Build option: define DMEM_STACK_CTRL_SPSET_EN to enable SPSET (op_code 110);
// without it 110 is refused like the reserved code.
module dmem_stack_ctrl #(
  parameter logic [7:0] SP_INIT  = 8'hFF,
  parameter logic [7:0] SP_LIMIT = 8'h80
) (
  input  logic             clk,
  input  logic             rst_n,
  dmem_stack_ctrl_if.slave bus
);

  localparam logic [2:0] OP_LD   = 3'b000;
  localparam logic [2:0] OP_ST   = 3'b001;
  localparam logic [2:0] OP_PUSH = 3'b010;
  localparam logic [2:0] OP_POP  = 3'b011;
  localparam logic [2:0] OP_CALL = 3'b100;
  localparam logic [2:0] OP_RET  = 3'b101;
`ifdef DMEM_STACK_CTRL_SPSET_EN
  localparam logic [2:0] OP_SPSET = 3'b110;
`endif

  typedef enum logic [1:0] {
    IDLE,
    DEC,
    ACC,
    INC
  } state_e;

  state_e     state;
  logic [2:0] op_q;
  logic [7:0] sp_q;
`ifdef DMEM_STACK_CTRL_SPSET_EN
  logic [7:0] wdata_q;
`endif
  logic       ready_q;
  logic       done_q;
  logic       err_q;
  logic       wr_q;
  logic       s2_q;
  logic       s5_q;
  logic       rd_load_q;
  logic       pc_load_q;

  // Single FSM: every output is registered, so the values for a state are
  // loaded on the edge that enters it. Faults and one-cycle operations land in
  // ACC with op_done already set; ACC then tells "finished" from "POP/RET read
  // still pending" by looking at its own op_done register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= OP_LD;
      sp_q      <= SP_INIT;
`ifdef DMEM_STACK_CTRL_SPSET_EN
      wdata_q   <= 8'h00;
`endif
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      wr_q      <= 1'b0;
      s2_q      <= 1'b0;
      s5_q      <= 1'b0;
      rd_load_q <= 1'b0;
      pc_load_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      wr_q      <= 1'b0;
      rd_load_q <= 1'b0;
      pc_load_q <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.op_valid && ready_q) begin
            op_q    <= bus.op_code;
            ready_q <= 1'b0;
`ifdef DMEM_STACK_CTRL_SPSET_EN
            wdata_q <= bus.sp_wdata;
`endif
            case (bus.op_code)
              OP_LD: begin
                state     <= ACC;
                s2_q      <= 1'b0;
                rd_load_q <= 1'b1;
                done_q    <= 1'b1;
              end
              OP_ST: begin
                state  <= ACC;
                s2_q   <= 1'b0;
                s5_q   <= 1'b1;
                wr_q   <= 1'b1;
                done_q <= 1'b1;
              end
              OP_PUSH, OP_CALL: begin
                if (sp_q == SP_LIMIT) begin
                  state  <= ACC;
                  done_q <= 1'b1;
                  err_q  <= 1'b1;
                end else begin
                  state <= DEC;
                end
              end
              OP_POP, OP_RET: begin
                if (sp_q == SP_INIT) begin
                  state  <= ACC;
                  done_q <= 1'b1;
                  err_q  <= 1'b1;
                end else begin
                  state     <= ACC;
                  s2_q      <= 1'b1;
                  rd_load_q <= (bus.op_code == OP_POP);
                  pc_load_q <= (bus.op_code == OP_RET);
                end
              end
`ifdef DMEM_STACK_CTRL_SPSET_EN
              OP_SPSET: begin
                state  <= ACC;
                done_q <= 1'b1;
              end
`endif
              default: begin
                state  <= ACC;
                done_q <= 1'b1;
                err_q  <= 1'b1;
              end
            endcase
          end
        end

        DEC: begin
          sp_q   <= sp_q - 8'd1;
          state  <= ACC;
          s2_q   <= 1'b1;
          s5_q   <= (op_q == OP_PUSH);
          wr_q   <= 1'b1;
          done_q <= 1'b1;
        end

        ACC: begin
          if (done_q) begin
            state   <= IDLE;
            ready_q <= 1'b1;
            s2_q    <= 1'b0;
            s5_q    <= 1'b0;
`ifdef DMEM_STACK_CTRL_SPSET_EN
            if ((op_q == OP_SPSET) && !err_q) begin
              sp_q <= wdata_q;
            end
`endif
          end else begin
            state  <= INC;
            done_q <= 1'b1;
          end
        end

        INC: begin
          sp_q    <= sp_q + 8'd1;
          state   <= IDLE;
          ready_q <= 1'b1;
          s2_q    <= 1'b0;
          s5_q    <= 1'b0;
        end

        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
          s2_q    <= 1'b0;
          s5_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.op_ready = ready_q;
  assign bus.op_done  = done_q;
  assign bus.op_err   = err_q;
  assign bus.sp       = sp_q;
  assign bus.wr       = wr_q;
  assign bus.s2       = s2_q;
  assign bus.s5       = s5_q;
  assign bus.rd_load  = rd_load_q;
  assign bus.pc_load  = pc_load_q;

endmodule

// File: tb/tb_dmem_stack_ctrl.sv
// tb_dmem_stack_ctrl: directed and random operations against a behavioural
// stack/memory model; a small 256x8 memory with R0/Rn/NPC sources lives here.
module tb_dmem_stack_ctrl;

  localparam logic [7:0] SP_INIT  = 8'hFF;
  localparam logic [7:0] SP_LIMIT = 8'h80;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  dmem_stack_ctrl_if bus ();

  dmem_stack_ctrl #(.SP_INIT(SP_INIT), .SP_LIMIT(SP_LIMIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  logic [7:0] ref_sp;
  logic [7:0] r0, rn, npc, rn_cap, pc_cap;
  logic [7:0] addr, data_out;
  logic       mem_init;

  assign addr     = bus.s2 ? bus.sp : r0;
  assign data_out = mem[addr];

  // Data memory plus the Rn/PC capture registers fed from dataOut.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 7 + 3);
    end else if (bus.wr) begin
      mem[addr] <= bus.s5 ? rn : npc;
    end
    if (bus.rd_load) rn_cap <= data_out;
    if (bus.pc_load) pc_cap <= data_out;
  end

  function automatic logic [15:0] pk(input logic rdy, input logic dn, input logic er,
                                     input logic w, input logic a2, input logic a5,
                                     input logic rl, input logic pl, input logic [7:0] s);
    return {rdy, dn, er, w, a2, a5, rl, pl, s};
  endfunction

  function automatic logic [15:0] obs_vec();
    return {bus.op_ready, bus.op_done, bus.op_err, bus.wr, bus.s2, bus.s5,
            bus.rd_load, bus.pc_load, bus.sp};
  endfunction

  task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.op_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_output("reset_state", obs_vec(), pk(1, 0, 0, 0, 0, 0, 0, 0, SP_INIT));
    rst_n = 1'b1;
    ref_sp = SP_INIT;
  endtask

  // Issue one operation, compare every cycle up to the IDLE return against the
  // sequence the operation rules call for, then check any loaded value.
  task automatic apply_stimulus(input logic [2:0] code, input logic [7:0] wdata, input string tag);
    logic [15:0] exp_q[$];
    logic [7:0]  sp0, spm, spp, exp_ld;
    int          ld_kind;
    bit          fault;
    sp0 = ref_sp;
    spm = sp0 - 8'd1;
    spp = sp0 + 8'd1;
    ld_kind = 0;
    fault = 1'b0;
    exp_ld = 8'h00;
    exp_q = {};
    case (code)
      3'b000: begin
        exp_q.push_back(pk(0, 1, 0, 0, 0, 0, 1, 0, sp0));
        exp_ld = ref_mem[r0];
        ld_kind = 1;
      end
      3'b001: begin
        exp_q.push_back(pk(0, 1, 0, 1, 0, 1, 0, 0, sp0));
        ref_mem[r0] = rn;
      end
      3'b010, 3'b100: begin
        if (sp0 == SP_LIMIT) fault = 1'b1;
        else begin
          exp_q.push_back(pk(0, 0, 0, 0, 0, 0, 0, 0, sp0));
          exp_q.push_back(pk(0, 1, 0, 1, 1, code == 3'b010, 0, 0, spm));
          ref_mem[spm] = (code == 3'b010) ? rn : npc;
          ref_sp = spm;
        end
      end
      3'b011, 3'b101: begin
        if (sp0 == SP_INIT) fault = 1'b1;
        else begin
          exp_q.push_back(pk(0, 0, 0, 0, 1, 0, code == 3'b011, code == 3'b101, sp0));
          exp_q.push_back(pk(0, 1, 0, 0, 1, 0, 0, 0, sp0));
          exp_ld = ref_mem[sp0];
          ld_kind = (code == 3'b011) ? 1 : 2;
          ref_sp = spp;
        end
      end
`ifdef DMEM_STACK_CTRL_SPSET_EN
      3'b110: begin
        exp_q.push_back(pk(0, 1, 0, 0, 0, 0, 0, 0, sp0));
        ref_sp = wdata;
      end
`endif
      default: fault = 1'b1;
    endcase
    if (fault) exp_q.push_back(pk(0, 1, 1, 0, 0, 0, 0, 0, sp0));

    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.op_code  = code;
    bus.sp_wdata = wdata;
    @(posedge clk);
    foreach (exp_q[i]) begin
      @(negedge clk);
      bus.op_valid = 1'b0;
      check_output($sformatf("%s_cyc%0d", tag, i), obs_vec(), exp_q[i]);
    end
    @(negedge clk);
    check_output({tag, "_idle"}, obs_vec(), pk(1, 0, 0, 0, 0, 0, 0, 0, ref_sp));
    if (ld_kind == 1) check_output({tag, "_rn"}, {8'h00, rn_cap}, {8'h00, exp_ld});
    if (ld_kind == 2) check_output({tag, "_pc"}, {8'h00, pc_cap}, {8'h00, exp_ld});
  endtask

  initial begin
    logic [2:0] c;
    bus.op_valid = 1'b0;
    bus.op_code  = 3'b000;
    bus.sp_wdata = 8'h00;
    r0 = 8'h00; rn = 8'h00; npc = 8'h00;
    ref_sp = SP_INIT;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 7 + 3);
    mem_init = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    mem_init = 1'b0;
    check_output("reset_state", obs_vec(), pk(1, 0, 0, 0, 0, 0, 0, 0, SP_INIT));
    rst_n = 1'b1;

    // PUSH 5A, then CALL/RET round trip, then POP back to empty.
    rn = 8'h5A;
    apply_stimulus(3'b010, 8'h00, "push5a");
    check_output("mem_fe", {8'h00, mem[8'hFE]}, 16'h005A);
    npc = 8'h21;
    apply_stimulus(3'b100, 8'h00, "call");
    check_output("mem_fd", {8'h00, mem[8'hFD]}, 16'h0021);
    apply_stimulus(3'b101, 8'h00, "ret");
    apply_stimulus(3'b011, 8'h00, "pop");

    // Underflow straight after reset, and the reserved code.
    do_reset();
    apply_stimulus(3'b011, 8'h00, "pop_empty");
    apply_stimulus(3'b101, 8'h00, "ret_empty");
    apply_stimulus(3'b111, 8'h00, "reserved");

    // Fill the stack down to the limit, then overflow.
    for (int n = 0; n < 200 && ref_sp != SP_LIMIT; n++) begin
      rn = 8'($urandom);
      apply_stimulus(3'b010, 8'h00, "fill");
    end
    rn = 8'hEE;
    apply_stimulus(3'b010, 8'h00, "push_full");
    apply_stimulus(3'b100, 8'h00, "call_full");
    apply_stimulus(3'b011, 8'h00, "pop_top");

    // ST then LD at R0=10.
    r0 = 8'h10; rn = 8'h33;
    apply_stimulus(3'b001, 8'h00, "st");
    rn = 8'h00;
    apply_stimulus(3'b000, 8'h00, "ld");
    check_output("ld_val", {8'h00, rn_cap}, 16'h0033);

    // Random mix of every non-SPSET code.
    for (int k = 0; k < 80; k++) begin
      r0  = 8'($urandom);
      rn  = 8'($urandom);
      npc = 8'($urandom);
      c = 3'($urandom_range(0, 6));
      if (c == 3'b110) c = 3'b111;
      apply_stimulus(c, 8'($urandom), "rand");
    end

    // Reset during the DEC cycle of a PUSH: no write, no op_done.
    do_reset();
    rn = 8'h77;
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.op_code  = 3'b010;
    @(posedge clk);
    @(negedge clk);
    bus.op_valid = 1'b0;
    check_output("dec_before_reset", obs_vec(), pk(0, 0, 0, 0, 0, 0, 0, 0, SP_INIT));
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_output("abort_reset", obs_vec(), pk(1, 0, 0, 0, 0, 0, 0, 0, SP_INIT));
    rst_n = 1'b1;
    ref_sp = SP_INIT;
    @(negedge clk);
    check_output("abort_idle", obs_vec(), pk(1, 0, 0, 0, 0, 0, 0, 0, SP_INIT));
    check_output("abort_mem_fe", {8'h00, mem[8'hFE]}, {8'h00, ref_mem[8'hFE]});

    // SPSET C0: takes effect only in the feature build.
    apply_stimulus(3'b110, 8'hC0, "spset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
